i2s_rx: RTL and testbench



---
 rtl/i2s_rx.sv | 154 +++++++++++++++
 tb/tb_i2s_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: I2S master receiver for the ICS-43432 MEMS microphone.
// Generates bclk/lr_clk (64 bclk per frame), deserializes the 24-bit
// MSB-first mic word and keeps bits [23:8]. Each word is delivered on a
// valid/ready interface, and a sticky overflow flag records dropped words.
// Build option: define I2S_RX_STEREO_EN to deliver both channels. Without
// it only right-channel words are delivered, so every word presented on
// sample carries sample_ch = 1.
module i2s_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  bclk_period,
   input  logic        en,
   input  logic        sd,
   output logic        lr_clk,
   output logic        bclk,
   output logic        sample_vld,
   input  logic        sample_rdy,
   output logic [15:0] sample,
   output logic        sample_ch,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_STOP_PEND = 2'd2;

   logic [1:0]  state;
   logic [7:0]  latched_period;
   logic [7:0]  ccnt;
   logic [6:0]  bcnt;
   logic        sd_meta;
   logic        sd_sync;
   logic [15:0] shreg;
   logic        running;
   logic        tick;
   logic        cap;
   logic [4:0]  slot;
   logic [15:0] word;
   logic        word_done;
   logic        deliver;

   assign running   = (state != ST_IDLE);
   assign tick      = running && (8'(ccnt + 8'd1) == latched_period);
   assign cap       = tick & bcnt[0];
   assign slot      = bcnt[5:1];
   assign word      = {shreg[14:0], sd_sync};
   assign word_done = cap && (slot == 5'd16);

`ifdef I2S_RX_STEREO_EN
   assign deliver = word_done;
`else
   // Left-channel completions are ignored entirely, so they never overflow.
   assign deliver = word_done && bcnt[6];
`endif

   assign bclk   = bcnt[0];
   assign lr_clk = bcnt[6];
   assign busy   = running;

   // Two-flop synchronizer for the asynchronous mic data line.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         sd_meta <= 1'b0;
         sd_sync <= 1'b0;
      end else begin
         sd_meta <= sd;
         sd_sync <= sd_meta;
      end
   end

   // Run/stop control; a stop request waits for the end of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         latched_period <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state          <= ST_RUN;
                  latched_period <= bclk_period;
               end
            end
            ST_RUN: begin
               if (!en) state <= ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
               if (en)
                  state <= ST_RUN;
               else if (tick && (bcnt == 7'd127))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Clock-divider and bit counters; the last tick of a frame wraps both to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccnt <= 8'd0;
         bcnt <= 7'd0;
      end else if (!running) begin
         ccnt <= 8'd0;
         bcnt <= 7'd0;
      end else if (tick) begin
         ccnt <= 8'd0;
         bcnt <= bcnt + 7'd1;
      end else begin
         ccnt <= ccnt + 8'd1;
      end
   end

   // Shift slots 1..16 in MSB first; slot 0 is the I2S delay bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= 16'd0;
      end else if ((state == ST_IDLE) && en) begin
         shreg <= 16'd0;
      end else if (cap && (slot >= 5'd1) && (slot <= 5'd16)) begin
         shreg <= word;
      end
   end

   // Output word register with valid/ready handshake; a full register drops new words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_vld <= 1'b0;
         sample     <= 16'd0;
         sample_ch  <= 1'b0;
      end else if (deliver && (!sample_vld || sample_rdy)) begin
         sample_vld <= 1'b1;
         sample     <= word;
         sample_ch  <= bcnt[6];
      end else if (sample_rdy) begin
         sample_vld <= 1'b0;
      end
   end

   // Sticky overflow; setting wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (deliver && sample_vld && !sample_rdy)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed self-checking bench for i2s_rx. A behavioural
// ICS-43432 model drives sd from bclk/lr_clk; a monitor records each
// handshake transfer for comparison against hand-computed words.
// Expectations follow the I2S_RX_STEREO_EN build option.
module tb_i2s_rx;

`ifdef I2S_RX_STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  bclk_period = 8'd4;
   logic        en = 1'b0;
   logic        sd = 1'b0;
   logic        sample_rdy = 1'b1;
   logic        ovf_clr = 1'b0;
   logic        lr_clk;
   logic        bclk;
   logic        sample_vld;
   logic [15:0] sample;
   logic        sample_ch;
   logic        overflow;
   logic        busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0 = 0;

   logic [23:0] left_word = 24'h123456;
   logic [23:0] right_word = 24'hA5C37F;
   logic [23:0] mic_w;
   int          idx = 0;
   logic        prev_bclk = 1'b0;
   logic        prev_lr = 1'b0;

   logic [15:0] q_data[$];
   logic        q_ch[$];

   i2s_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bclk_period (bclk_period),
      .en          (en),
      .sd          (sd),
      .lr_clk      (lr_clk),
      .bclk        (bclk),
      .sample_vld  (sample_vld),
      .sample_rdy  (sample_rdy),
      .sample      (sample),
      .sample_ch   (sample_ch),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Microphone model: new bit after each bclk fall, MSB one slot after lr_clk changes.
   always @(negedge clk) begin
      if (!busy) begin
         idx = 0;
         sd  = 1'b0;
      end else if (prev_bclk && !bclk) begin
         if (lr_clk != prev_lr) idx = 0;
         else idx = idx + 1;
         mic_w = lr_clk ? right_word : left_word;
         sd = (idx >= 1 && idx <= 24) ? mic_w[24 - idx] : 1'b0;
      end
      prev_bclk = bclk;
      prev_lr   = lr_clk;
   end

   // Transfer monitor: records words accepted at the next rising edge.
   always @(negedge clk) begin
      #1;
      if (rst_n && sample_vld && sample_rdy) begin
         q_data.push_back(sample);
         q_ch.push_back(sample_ch);
      end
   end

   task automatic start(input logic [7:0] p);
      bclk_period = p;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      t0 = cyc;
   endtask

   task automatic wait_to(input int k);
      while (cyc < t0 + k) @(negedge clk);
   endtask

   task automatic stop_idle();
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int i = 0; i < budget && q_data.size() < n; i++) @(negedge clk);
   endtask

   task automatic clear_q();
      q_data.delete();
      q_ch.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if (bclk !== 1'b0) begin bad++; $display("FAIL reset_bclk got=%b exp=0", bclk); end
      total++; if (lr_clk !== 1'b0) begin bad++; $display("FAIL reset_lr_clk got=%b exp=0", lr_clk); end
      total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", sample_vld); end
      total++; if (sample !== 16'h0000) begin bad++; $display("FAIL reset_sample got=%h exp=0000", sample); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0 || bclk !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b bclk=%b exp=0,0", busy, bclk); end
   endtask

   task automatic test_capture();
      logic [15:0] exp_d [3];
      logic        exp_c [3];
      int          r0;
      exp_d[0] = STEREO ? 16'h1234 : 16'hA5C3;
      exp_d[1] = 16'hA5C3;
      exp_d[2] = STEREO ? 16'h1234 : 16'hA5C3;
      exp_c[0] = STEREO ? 1'b0 : 1'b1;
      exp_c[1] = 1'b1;
      exp_c[2] = STEREO ? 1'b0 : 1'b1;
      clear_q();
      start(8'd4);
      while (!bclk && cyc - t0 < 100) @(negedge clk);
      total++; if (cyc - t0 !== 4) begin bad++; $display("FAIL first_bclk_rise got=%0d exp=4", cyc - t0); end
      r0 = cyc;
      while (bclk && cyc - r0 < 100) @(negedge clk);
      while (!bclk && cyc - r0 < 100) @(negedge clk);
      total++; if (cyc - r0 !== 8) begin bad++; $display("FAIL bclk_period got=%0d exp=8", cyc - r0); end
      r0 = cyc;
      while (!lr_clk && cyc - r0 < 2000) @(negedge clk);
      r0 = cyc;
      while (lr_clk && cyc - r0 < 2000) @(negedge clk);
      while (!lr_clk && cyc - r0 < 2000) @(negedge clk);
      total++; if (cyc - r0 !== 512) begin bad++; $display("FAIL lr_clk_period got=%0d exp=512", cyc - r0); end
      wait_words(3, 3000);
      total++; if (q_data.size() < 3) begin bad++; $display("FAIL capture_count got=%0d exp>=3", q_data.size()); end
      for (int i = 0; i < 3; i++) begin
         if (q_data.size() > i) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL capture_word%0d got=%h exp=%h", i, q_data[i], exp_d[i]); end
            total++; if (q_ch[i] !== exp_c[i]) begin bad++; $display("FAIL capture_ch%0d got=%b exp=%b", i, q_ch[i], exp_c[i]); end
         end
      end
      stop_idle();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL capture_stop busy got=%b exp=0", busy); end
   endtask

   task automatic test_overflow();
      logic [15:0] first_d;
      logic        first_c;
      first_d = STEREO ? 16'h1234 : 16'hA5C3;
      first_c = STEREO ? 1'b0 : 1'b1;
      clear_q();
      sample_rdy = 1'b0;
      start(8'd4);
      wait_to(STEREO ? 800 : 1500);
      total++; if (sample_vld !== 1'b1) begin bad++; $display("FAIL ovf_vld_held got=%b exp=1", sample_vld); end
      total++; if (sample !== first_d) begin bad++; $display("FAIL ovf_word_held got=%h exp=%h", sample, first_d); end
      total++; if (sample_ch !== first_c) begin bad++; $display("FAIL ovf_ch_held got=%b exp=%b", sample_ch, first_c); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      sample_rdy = 1'b1;
      @(negedge clk);
      #2;
      total++; if (q_data.size() !== 1) begin bad++; $display("FAIL ovf_xfer_count got=%0d exp=1", q_data.size()); end
      if (q_data.size() > 0) begin
         total++; if (q_data[0] !== first_d) begin bad++; $display("FAIL ovf_xfer_word got=%h exp=%h", q_data[0], first_d); end
      end
      total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL ovf_vld_clear got=%b exp=0", sample_vld); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
      stop_idle();
   endtask

   task automatic test_stop();
      clear_q();
      sample_rdy = 1'b1;
      start(8'd4);
      wait_to(161);
      en = 1'b0;
      wait_to(300);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_pend_busy got=%b exp=1", busy); end
      wait_to(511);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_frame_end_busy got=%b exp=1", busy); end
      wait_to(512);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle_busy got=%b exp=0", busy); end
      total++; if (bclk !== 1'b0 || lr_clk !== 1'b0) begin bad++; $display("FAIL stop_idle_clks bclk=%b lr=%b exp=0,0", bclk, lr_clk); end
      total++; if (q_data.size() !== (STEREO ? 2 : 1)) begin bad++; $display("FAIL stop_word_count got=%0d exp=%0d", q_data.size(), STEREO ? 2 : 1); end
      if (q_data.size() > 0) begin
         total++; if (q_data[q_data.size()-1] !== 16'hA5C3 || q_ch[q_ch.size()-1] !== 1'b1) begin bad++; $display("FAIL stop_right_word got=%h/%b exp=a5c3/1", q_data[q_data.size()-1], q_ch[q_ch.size()-1]); end
      end
      start(8'd4);
      wait_to(161);
      en = 1'b0;
      wait_to(241);
      en = 1'b1;
      wait_to(600);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL reassert_busy got=%b exp=1", busy); end
      wait_to(1100);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL reassert_busy_later got=%b exp=1", busy); end
      stop_idle();
   endtask

   task automatic test_reset_mid();
      clear_q();
      sample_rdy = 1'b0;
      start(8'd4);
      wait_to(713);
      total++; if (sample_vld !== 1'b1) begin bad++; $display("FAIL midrst_pre_vld got=%b exp=1", sample_vld); end
      rst_n = 1'b0;
      #1;
      total++; if (bclk !== 1'b0 || lr_clk !== 1'b0) begin bad++; $display("FAIL midrst_clks bclk=%b lr=%b exp=0,0", bclk, lr_clk); end
      total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b exp=0", sample_vld); end
      total++; if (sample !== 16'h0000) begin bad++; $display("FAIL midrst_sample got=%h exp=0000", sample); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      left_word  = 24'h00FF00;
      right_word = 24'h7E8155;
      sample_rdy = 1'b1;
      clear_q();
      start(8'd4);
      wait_words(1, 1000);
      total++; if (q_data.size() < 1) begin bad++; $display("FAIL midrst_word_count got=%0d exp>=1", q_data.size()); end
      if (q_data.size() > 0) begin
         total++; if (q_data[0] !== (STEREO ? 16'h00FF : 16'h7E81)) begin bad++; $display("FAIL midrst_first_word got=%h exp=%h", q_data[0], STEREO ? 16'h00FF : 16'h7E81); end
         total++; if (q_ch[0] !== (STEREO ? 1'b0 : 1'b1)) begin bad++; $display("FAIL midrst_first_ch got=%b exp=%b", q_ch[0], STEREO ? 1'b0 : 1'b1); end
      end
      stop_idle();
   endtask

   task automatic test_slow();
      left_word  = 24'h800000;
      right_word = 24'h800000;
      clear_q();
      start(8'd255);
      while (!bclk && cyc - t0 < 1000) @(negedge clk);
      total++; if (cyc - t0 !== 255) begin bad++; $display("FAIL slow_first_rise got=%0d exp=255", cyc - t0); end
      wait_words(1, 30000);
      total++; if (q_data.size() < 1) begin bad++; $display("FAIL slow_word_count got=%0d exp>=1", q_data.size()); end
      if (q_data.size() > 0) begin
         total++; if (q_data[0] !== 16'h8000) begin bad++; $display("FAIL slow_word got=%h exp=8000", q_data[0]); end
         total++; if (q_ch[0] !== (STEREO ? 1'b0 : 1'b1)) begin bad++; $display("FAIL slow_ch got=%b exp=%b", q_ch[0], STEREO ? 1'b0 : 1'b1); end
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_overflow();
      test_stop();
      test_reset_mid();
      test_slow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
